ipl_interrupt_unit: RTL and testbench

//   Consumes the active-low 3-bit IPL code from the interrupt priority encoder.

---
 rtl/ipl_interrupt_unit.sv | 110 +++++++++++
 tb/tb_ipl_interrupt_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ipl_interrupt_unit.sv
// rtl/ipl_interrupt_unit.sv - IPL synchroniser/filter, NMI edge latch and interrupt-acknowledge sequencer
module ipl_interrupt_unit #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ipl_n,
  input  logic [2:0] sr_mask,
  input  logic       iack_start,
  input  logic       dtack_n,
  input  logic       vpa_n,
  input  logic       berr_n,
  input  logic [7:0] data_in,
  output logic       int_pending,
  output logic [2:0] int_level,
  output logic       iack_cycle,
  output logic [2:0] iack_level,
  output logic [7:0] vector,
  output logic       vector_valid
);

  localparam logic [7:0] SPURIOUS_VEC = 8'd24;
  localparam logic [7:0] TIMEOUT_VAL  = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, IACK, VECTOR} state_t;

  state_t     state_q, state_d;
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] level_q, level_d;
  logic       nmi_q, nmi_d;
  logic       pending_q, pending_d;
  logic [2:0] iack_level_q;
  logic [7:0] vector_q, vector_d;
  logic [7:0] count_q;
  logic       term;

  always_comb begin
    state_d      = state_q;
    vector_d     = vector_q;
    term         = 1'b0;
    iack_cycle   = 1'b0;
    vector_valid = 1'b0;
    // The sample entering the last stage is compared with the one already there,
    // so the level moves SYNC_STAGES+1 cycles after ipl_n and ignores 1-cycle glitches.
    level_d = (sync_q[SYNC_STAGES-2] == sync_q[SYNC_STAGES-1]) ? ~sync_q[SYNC_STAGES-1] : level_q;

    case (state_q)
      IDLE: begin
        if (iack_start && pending_q) state_d = IACK;
      end
      IACK: begin
        iack_cycle = 1'b1;
        term       = 1'b1;
        if (!berr_n)                  vector_d = SPURIOUS_VEC;
        else if (!vpa_n)              vector_d = SPURIOUS_VEC + {5'd0, iack_level_q};
        else if (!dtack_n)            vector_d = data_in;
        else if (count_q == TIMEOUT_VAL) vector_d = SPURIOUS_VEC;
        else                          term = 1'b0;
        if (term) state_d = VECTOR;
      end
      VECTOR: begin
        vector_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh 7-edge in the same cycle as the level-7 acknowledge must survive.
    nmi_d = nmi_q;
    if (term && iack_level_q == 3'd7) nmi_d = 1'b0;
    if (level_d == 3'd7 && level_q != 3'd7) nmi_d = 1'b1;

    pending_d = (state_d == IDLE) &&
                (nmi_d || (level_d != 3'd0 && level_d > sr_mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b111;
      state_q      <= IDLE;
      level_q      <= 3'd0;
      nmi_q        <= 1'b0;
      pending_q    <= 1'b0;
      iack_level_q <= 3'd0;
      vector_q     <= 8'h00;
      count_q      <= 8'd0;
    end else begin
      sync_q[0] <= ipl_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      state_q   <= state_d;
      level_q   <= level_d;
      nmi_q     <= nmi_d;
      pending_q <= pending_d;
      vector_q  <= vector_d;
      if (state_q == IDLE && state_d == IACK) begin
        iack_level_q <= level_q;
        count_q      <= 8'd0;
      end else if (state_q == IACK) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign int_pending = pending_q;
  assign int_level   = level_q;
  assign iack_level  = iack_level_q;
  assign vector      = vector_q;

endmodule

// File: tb/tb_ipl_interrupt_unit.sv
// tb/tb_ipl_interrupt_unit.sv - directed self-checking bench for ipl_interrupt_unit
module tb_ipl_interrupt_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ipl_n;
  logic [2:0] sr_mask;
  logic       iack_start;
  logic       dtack_n;
  logic       vpa_n;
  logic       berr_n;
  logic [7:0] data_in;
  logic       int_pending;
  logic [2:0] int_level;
  logic       iack_cycle;
  logic [2:0] iack_level;
  logic [7:0] vector;
  logic       vector_valid;

  int n_cmp = 0;
  int n_bad = 0;

  ipl_interrupt_unit #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .ipl_n(ipl_n), .sr_mask(sr_mask), .iack_start(iack_start),
    .dtack_n(dtack_n), .vpa_n(vpa_n), .berr_n(berr_n), .data_in(data_in),
    .int_pending(int_pending), .int_level(int_level), .iack_cycle(iack_cycle),
    .iack_level(iack_level), .vector(vector), .vector_valid(vector_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    rst = 1'b1; ipl_n = 3'b111; sr_mask = 3'd0; iack_start = 1'b0;
    dtack_n = 1'b1; vpa_n = 1'b1; berr_n = 1'b1; data_in = 8'h00;
    step(3);
    rst = 1'b0;
    check("rst_level", int_level, 0);
    check("rst_pending", int_pending, 0);
    check("rst_iack", iack_cycle, 0);
    check("rst_vector", vector, 0);
    check("rst_valid", vector_valid, 0);

    // filter: level 2 below mask 3
    sr_mask = 3'd3; ipl_n = 3'b101;
    step(2);
    check("flt_latency", int_level, 0);
    step(1);
    check("flt_lvl2", int_level, 2);
    check("flt_pend2", int_pending, 0);
    ipl_n = 3'b010;
    step(3);
    check("flt_lvl5", int_level, 5);
    check("flt_pend5", int_pending, 1);
    ipl_n = 3'b000; step(1); ipl_n = 3'b010;
    step(4);
    check("glitch_lvl", int_level, 5);

    // autovector, with IPL moving during IACK
    iack_start = 1'b1; step(1); iack_start = 1'b0;
    check("av_iack", iack_cycle, 1);
    check("av_ilvl", iack_level, 5);
    check("av_pend", int_pending, 0);
    ipl_n = 3'b100;
    step(3);
    check("av_ilvl_hold", iack_level, 5);
    check("av_newlvl", int_level, 3);
    vpa_n = 1'b0; step(1); vpa_n = 1'b1;
    check("av_valid", vector_valid, 1);
    check("av_vector", vector, 29);
    check("av_iack_off", iack_cycle, 0);
    step(1);
    check("av_valid_1cyc", vector_valid, 0);
    check("av_vec_hold", vector, 29);
    check("av_pend_after", int_pending, 0);

    // vectored: level 3, mask 0
    sr_mask = 3'd0; step(1);
    check("vec_pend", int_pending, 1);
    iack_start = 1'b1; step(1); iack_start = 1'b0;
    dtack_n = 1'b0; data_in = 8'h40; step(1); dtack_n = 1'b1;
    check("vec_valid", vector_valid, 1);
    check("vec_vector", vector, 8'h40);
    step(1);
    iack_start = 1'b1; step(1); iack_start = 1'b0;
    dtack_n = 1'b0; berr_n = 1'b0; step(1); dtack_n = 1'b1; berr_n = 1'b1;
    check("berr_vector", vector, 24);
    step(1);

    // NMI edge behaviour under mask 7
    sr_mask = 3'd7; ipl_n = 3'b000;
    step(3);
    check("nmi_lvl", int_level, 7);
    check("nmi_pend", int_pending, 1);
    iack_start = 1'b1; step(1); iack_start = 1'b0;
    check("nmi_ilvl", iack_level, 7);
    vpa_n = 1'b0; step(1); vpa_n = 1'b1;
    check("nmi_vector", vector, 31);
    step(1);
    check("nmi_cleared", int_pending, 0);
    step(5);
    check("nmi_held7", int_pending, 0);
    ipl_n = 3'b001; step(3);
    check("nmi_lvl6", int_level, 6);
    check("nmi_pend6", int_pending, 0);
    ipl_n = 3'b000; step(3);
    check("nmi_reedge", int_pending, 1);

    // timeout: no response, spurious vector after TIMEOUT_CYCLES+1 IACK cycles
    iack_start = 1'b1; step(1); iack_start = 1'b0;
    waited = 0;
    while (!vector_valid && waited < 400) begin
      step(1);
      waited++;
    end
    check("to_cycles", waited, 256);
    check("to_vector", vector, 24);
    step(1);

    // reset in the middle of an IACK cycle
    sr_mask = 3'd0; step(1);
    check("rstm_pend", int_pending, 1);
    iack_start = 1'b1; step(1); iack_start = 1'b0;
    check("rstm_iack", iack_cycle, 1);
    rst = 1'b1; step(1);
    check("rstm_iack0", iack_cycle, 0);
    check("rstm_valid0", vector_valid, 0);
    check("rstm_vector0", vector, 0);
    check("rstm_ilvl0", iack_level, 0);
    check("rstm_pend0", int_pending, 0);
    check("rstm_lvl0", int_level, 0);
    rst = 1'b0; step(1);
    check("rstm_novalid", vector_valid, 0);
    check("rstm_idle", iack_cycle, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
